// File: rtl/microc_uc_pkg.sv
// ---------------------------------------------------------------------------
// microc_uc_pkg
// Shared definitions for the microc control unit.
// Contents:
//   - default widths (OPW_DEF, ALUW_DEF) and the default WAIT length
//   - opcode encodings for the non-ALU instructions
//   - control-unit state encoding (state_t)
// Opcodes with the MSB set are ALU operations: 1oooxx, where ooo is ALUOp.
// ---------------------------------------------------------------------------
package microc_uc_pkg;

    localparam int OPW_DEF         = 6;
    localparam int ALUW_DEF        = 3;
    localparam int WAIT_CYCLES_DEF = 4;

    localparam logic [OPW_DEF-1:0] OP_NOP  = 6'b000000;
    localparam logic [OPW_DEF-1:0] OP_LI   = 6'b000001;
    localparam logic [OPW_DEF-1:0] OP_J    = 6'b000010;
    localparam logic [OPW_DEF-1:0] OP_JZ   = 6'b000011;
    localparam logic [OPW_DEF-1:0] OP_JNZ  = 6'b000100;
    localparam logic [OPW_DEF-1:0] OP_WAIT = 6'b000101;
    localparam logic [OPW_DEF-1:0] OP_HALT = 6'b000110;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

endpackage

// File: rtl/microc_uc_dec.sv
// ---------------------------------------------------------------------------
// microc_uc_dec
// Purely combinational instruction decoder for the microc control unit.
// Produces the datapath controls an instruction needs while it executes;
// the top gates these so they only reach the datapath in EXEC.
// Ports:
//   ir     in   OPW   latched instruction opcode
//   zero   in   1     datapath zero flag (used by JZ / JNZ)
//   pc_we  out  1     PC load enable
//   s_inc  out  1     PC mux: 1 = PC+1, 0 = jump target
//   s_inm  out  1     regfile write mux: 1 = immediate, 0 = ALU result
//   we     out  1     register file write enable
//   wez    out  1     zero flag write enable
//   aluop  out  ALUW  ALU operation select (ALU instructions only)
//   bad    out  1     opcode is undefined (executes as NOP)
// ---------------------------------------------------------------------------
module microc_uc_dec
    import microc_uc_pkg::*;
#(
    parameter int OPW  = OPW_DEF,
    parameter int ALUW = ALUW_DEF
) (
    input  logic [OPW-1:0]  ir,
    input  logic            zero,
    output logic            pc_we,
    output logic            s_inc,
    output logic            s_inm,
    output logic            we,
    output logic            wez,
    output logic [ALUW-1:0] aluop,
    output logic            bad
);

    always_comb begin
        pc_we = 1'b0;
        s_inc = 1'b0;
        s_inm = 1'b0;
        we    = 1'b0;
        wez   = 1'b0;
        aluop = '0;
        bad   = 1'b0;

        if (ir[OPW-1]) begin
            // ALU class: 1oooxx, the two low bits are don't-care.
            pc_we = 1'b1;
            s_inc = 1'b1;
            we    = 1'b1;
            wez   = 1'b1;
            aluop = ir[OPW-2 -: ALUW];
        end else begin
            case (ir)
                OP_NOP: begin
                    pc_we = 1'b1;
                    s_inc = 1'b1;
                end
                OP_LI: begin
                    pc_we = 1'b1;
                    s_inc = 1'b1;
                    s_inm = 1'b1;
                    we    = 1'b1;
                end
                OP_J: begin
                    pc_we = 1'b1;
                end
                OP_JZ: begin
                    // Take the jump (s_inc=0) when the flag is set.
                    pc_we = 1'b1;
                    s_inc = ~zero;
                end
                OP_JNZ: begin
                    pc_we = 1'b1;
                    s_inc = zero;
                end
                OP_WAIT: begin
                    pc_we = 1'b1;
                    s_inc = 1'b1;
                end
                OP_HALT: begin
                    // PC holds so it keeps pointing at the HALT.
                end
                default: begin
                    // Undefined opcodes behave as NOP and get flagged.
                    pc_we = 1'b1;
                    s_inc = 1'b1;
                    bad   = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/microc_uc.sv
// ---------------------------------------------------------------------------
// microc_uc
// Multicycle control unit for the microc datapath. Each instruction takes a
// FETCH cycle (opcode latched into ir) and an EXEC cycle (controls driven).
// WAIT adds WAIT_CYCLES stall cycles; HALT parks the unit until reset.
// Ports:
//   clk      in   1     clock, rising edge
//   reset    in   1     synchronous, active-high
//   start    in   1     leave IDLE and begin fetching (ignored elsewhere)
//   Opcode   in   OPW   instruction opcode, sampled only in FETCH
//   zero     in   1     datapath zero flag, used in EXEC
//   s_inc    out  1     PC mux: 1 = PC+1, 0 = jump target
//   s_inm    out  1     regfile write mux: 1 = immediate, 0 = ALU result
//   we       out  1     register file write enable
//   wez      out  1     zero flag write enable
//   ALUOp    out  ALUW  ALU operation select
//   pc_we    out  1     PC load enable
//   busy     out  1     high in FETCH, EXEC, WAIT
//   halted   out  1     high in HALT
//   illegal  out  1     sticky: an undefined opcode executed since reset
// Datapath controls are combinational from (state, ir, zero) and are only
// non-zero in EXEC.
// ---------------------------------------------------------------------------
module microc_uc
    import microc_uc_pkg::*;
#(
    parameter int OPW         = OPW_DEF,
    parameter int ALUW        = ALUW_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [OPW-1:0]  Opcode,
    input  logic            zero,
    output logic            s_inc,
    output logic            s_inm,
    output logic            we,
    output logic            wez,
    output logic [ALUW-1:0] ALUOp,
    output logic            pc_we,
    output logic            busy,
    output logic            halted,
    output logic            illegal
);

    // Counter only needs to hold WAIT_CYCLES-1; keep at least one bit.
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES - 1);

    state_t         state_reg;
    logic [OPW-1:0] ir_reg;
    logic [CW-1:0]  wait_cnt_reg;
    logic           illegal_reg;

    logic            dec_pc_we;
    logic            dec_s_inc;
    logic            dec_s_inm;
    logic            dec_we;
    logic            dec_wez;
    logic [ALUW-1:0] dec_aluop;
    logic            dec_bad;
    logic            in_exec;

    microc_uc_dec #(
        .OPW  (OPW),
        .ALUW (ALUW)
    ) u_dec (
        .ir    (ir_reg),
        .zero  (zero),
        .pc_we (dec_pc_we),
        .s_inc (dec_s_inc),
        .s_inm (dec_s_inm),
        .we    (dec_we),
        .wez   (dec_wez),
        .aluop (dec_aluop),
        .bad   (dec_bad)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            ir_reg       <= '0;
            wait_cnt_reg <= '0;
            illegal_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    ir_reg    <= Opcode;
                    state_reg <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (dec_bad) begin
                        illegal_reg <= 1'b1;
                    end
                    if (ir_reg == OP_WAIT) begin
                        // Load N-1 so the count-down to 0 spans N cycles.
                        wait_cnt_reg <= WAIT_LOAD;
                        state_reg    <= ST_WAIT;
                    end else if (ir_reg == OP_HALT) begin
                        state_reg <= ST_HALT;
                    end else begin
                        state_reg <= ST_FETCH;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_reg == '0) begin
                        state_reg <= ST_FETCH;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 1'b1;
                    end
                end
                ST_HALT: begin
                    state_reg <= ST_HALT;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_exec = (state_reg == ST_EXEC);

    assign pc_we = in_exec & dec_pc_we;
    assign s_inc = in_exec & dec_s_inc;
    assign s_inm = in_exec & dec_s_inm;
    assign we    = in_exec & dec_we;
    assign wez   = in_exec & dec_wez;

    genvar gi;
    generate
        for (gi = 0; gi < ALUW; gi++) begin : g_aluop
            assign ALUOp[gi] = in_exec & dec_aluop[gi];
        end
    endgenerate

    assign busy    = (state_reg == ST_FETCH) || (state_reg == ST_EXEC) ||
                     (state_reg == ST_WAIT);
    assign halted  = (state_reg == ST_HALT);
    assign illegal = illegal_reg;

endmodule

// File: tb/tb_microc_uc.sv
// ---------------------------------------------------------------------------
// tb_microc_uc
// Self-checking bench for microc_uc: directed table of instructions, hand
// sequences for WAIT/HALT/reset corners, then random instruction streams
// checked against an instruction-level expectation model.
// ---------------------------------------------------------------------------
module tb_microc_uc;

    localparam int NWAIT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] Opcode;
    logic       zero;
    logic       s_inc, s_inm, we, wez, pc_we, busy, halted, illegal;
    logic [2:0] ALUOp;

    microc_uc #(
        .OPW         (6),
        .ALUW        (3),
        .WAIT_CYCLES (NWAIT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .Opcode  (Opcode),
        .zero    (zero),
        .s_inc   (s_inc),
        .s_inm   (s_inm),
        .we      (we),
        .wez     (wez),
        .ALUOp   (ALUOp),
        .pc_we   (pc_we),
        .busy    (busy),
        .halted  (halted),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    // ctrl = {pc_we, s_inc, s_inm, we, wez, ALUOp[2:0]}
    typedef struct packed {
        logic [7:0] ctrl;
        logic       busy;
        logic       halted;
        logic       illegal;
    } obs_t;

    typedef struct {
        logic [5:0] op;
        logic       z;
        logic [7:0] ctrl;
        logic       bad;
        string      name;
    } vec_t;

    int   n_pass  = 0;
    int   n_total = 0;
    logic ill_m   = 1'b0;   // expected sticky illegal flag

    function automatic obs_t sample();
        obs_t o;
        o.ctrl    = {pc_we, s_inc, s_inm, we, wez, ALUOp};
        o.busy    = busy;
        o.halted  = halted;
        o.illegal = illegal;
        return o;
    endfunction

    function automatic obs_t mk(input logic [7:0] c, input logic b,
                                input logic h, input logic il);
        obs_t o;
        o.ctrl = c; o.busy = b; o.halted = h; o.illegal = il;
        return o;
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t got;
        got = sample();
        n_total++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %-14s ctrl=%b busy=%b halted=%b illegal=%b",
                     name, got.ctrl, got.busy, got.halted, got.illegal);
        end else begin
            $display("FAIL %-14s got ctrl=%b busy=%b halted=%b illegal=%b, expected ctrl=%b busy=%b halted=%b illegal=%b",
                     name, got.ctrl, got.busy, got.halted, got.illegal,
                     exp.ctrl, exp.busy, exp.halted, exp.illegal);
        end
    endtask

    // Reference: controls an opcode should drive while it executes.
    function automatic logic [7:0] model_ctrl(input logic [5:0] op, input logic z);
        int alu_sel;
        if (op >= 6'd32) begin
            alu_sel = (op - 32) / 4;
            return {5'b11011, 3'(alu_sel)};
        end
        case (op)
            6'd1:    return 8'b1111_0000;
            6'd2:    return 8'b1000_0000;
            6'd3:    return z ? 8'b1000_0000 : 8'b1100_0000;
            6'd4:    return z ? 8'b1100_0000 : 8'b1000_0000;
            6'd6:    return 8'b0000_0000;
            default: return 8'b1100_0000;  // NOP, WAIT, undefined
        endcase
    endfunction

    function automatic logic model_bad(input logic [5:0] op);
        return (op > 6'd6) && (op < 6'd32);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ill_m = 1'b0;
    endtask

    // From IDLE at a negedge: pulse start; returns at the negedge in FETCH.
    task automatic go();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered at a negedge while the DUT is in FETCH; returns at the
    // negedge of the next FETCH (non-HALT opcodes only).
    task automatic do_instr(input logic [5:0] op, input logic z,
                            input logic [7:0] ctrl, input logic bad,
                            input string name);
        Opcode = op;
        zero   = z;
        start  = 1'($urandom);
        check({name, ".F"}, mk(8'h00, 1'b1, 1'b0, ill_m));
        @(negedge clk);
        check({name, ".E"}, mk(ctrl, 1'b1, 1'b0, ill_m));
        Opcode = 6'($urandom);   // must be ignored outside FETCH
        if (bad) ill_m = 1'b1;
        if (op == 6'd5) begin
            for (int i = 0; i < NWAIT; i++) begin
                @(negedge clk);
                zero = 1'($urandom);
                check({name, ".W"}, mk(8'h00, 1'b1, 1'b0, ill_m));
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    vec_t tbl[$];

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        Opcode = 6'd0;
        zero   = 1'b0;

        tbl.push_back('{6'b110100, 1'b0, 8'b11011101, 1'b0, "alu101"});
        tbl.push_back('{6'b000000, 1'b1, 8'b11000000, 1'b0, "nop"});
        tbl.push_back('{6'b000001, 1'b0, 8'b11110000, 1'b0, "li"});
        tbl.push_back('{6'b000010, 1'b1, 8'b10000000, 1'b0, "j"});
        tbl.push_back('{6'b000011, 1'b1, 8'b10000000, 1'b0, "jz_z1"});
        tbl.push_back('{6'b000011, 1'b0, 8'b11000000, 1'b0, "jz_z0"});
        tbl.push_back('{6'b000100, 1'b1, 8'b11000000, 1'b0, "jnz_z1"});
        tbl.push_back('{6'b000100, 1'b0, 8'b10000000, 1'b0, "jnz_z0"});
        tbl.push_back('{6'b000101, 1'b0, 8'b11000000, 1'b0, "wait"});
        tbl.push_back('{6'b100010, 1'b1, 8'b11011000, 1'b0, "alu000"});
        tbl.push_back('{6'b111111, 1'b0, 8'b11011111, 1'b0, "alu111"});
        tbl.push_back('{6'b011111, 1'b0, 8'b11000000, 1'b1, "ill_1f"});
        tbl.push_back('{6'b000001, 1'b1, 8'b11110000, 1'b0, "li_sticky"});
        tbl.push_back('{6'b000111, 1'b0, 8'b11000000, 1'b1, "ill_07"});
        tbl.push_back('{6'b101001, 1'b1, 8'b11011010, 1'b0, "alu010"});

        // 1: idle after reset, no start
        do_reset();
        for (int i = 0; i < 10; i++) begin
            Opcode = 6'($urandom);
            zero   = 1'($urandom);
            @(negedge clk);
            check("idle", mk(8'h00, 1'b0, 1'b0, 1'b0));
        end

        // 2,3,6: directed table
        go();
        foreach (tbl[i])
            do_instr(tbl[i].op, tbl[i].z, tbl[i].ctrl, tbl[i].bad, tbl[i].name);

        // Reset with start in the same cycle stays in IDLE
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        ill_m = 1'b0;
        check("rst+start", mk(8'h00, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        check("rst+start+1", mk(8'h00, 1'b0, 1'b0, 1'b0));

        // 4: reset on the second WAIT cycle
        go();
        Opcode = 6'd5;
        check("w.F", mk(8'h00, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        check("w.E", mk(8'b11000000, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        check("w.W1", mk(8'h00, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        check("w.W2", mk(8'h00, 1'b1, 1'b0, 1'b0));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("w.rst", mk(8'h00, 1'b0, 1'b0, 1'b0));

        // 5: HALT, stays halted with start toggling, reset recovers
        go();
        do_instr(6'b011111, 1'b0, 8'b11000000, 1'b1, "pre_halt_ill");
        Opcode = 6'd6;
        zero   = 1'($urandom);
        check("h.F", mk(8'h00, 1'b1, 1'b0, ill_m));
        @(negedge clk);
        check("h.E", mk(8'h00, 1'b1, 1'b0, ill_m));
        for (int i = 0; i < 20; i++) begin
            start  = 1'($urandom);
            Opcode = 6'($urandom);
            @(negedge clk);
            check("h.stay", mk(8'h00, 1'b0, 1'b1, ill_m));
        end
        start = 1'b0;
        do_reset();
        check("h.rst", mk(8'h00, 1'b0, 1'b0, 1'b0));

        // Random streams against the reference model
        for (int r = 0; r < 3; r++) begin
            logic [5:0] op;
            logic       z;
            do_reset();
            go();
            for (int k = 0; k < 120; k++) begin
                op = 6'($urandom_range(0, 63));
                if (op == 6'd6) op = 6'd0;
                z  = 1'($urandom);
                do_instr(op, z, model_ctrl(op, z), model_bad(op), "rnd");
            end
            Opcode = 6'd6;
            check("rnd.hF", mk(8'h00, 1'b1, 1'b0, ill_m));
            @(negedge clk);
            check("rnd.hE", mk(8'h00, 1'b1, 1'b0, ill_m));
            @(negedge clk);
            check("rnd.halt", mk(8'h00, 1'b0, 1'b1, ill_m));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
